dmem_bridge: RTL
================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter RAM_AW, default 12, word-address width of the internal RAM (4096 words).
REQ-002 Parameter DEBOUNCE_CYC, default 20, stable cycles required before a switch change is accepted.
REQ-003 Parameter SCAN_CYC, default 50000, cycles each display digit stays lit.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-high despite the name.
REQ-006 addr  input  32  byte address from CPU MEM stage (ALU result).
REQ-007 we  input  1  store strobe from CPU MEM stage.
REQ-008 wdata  input  32  store data (rs2 value).
REQ-009 rdata  output  32  load data back to CPU, combinational from addr.
REQ-010 sw  input  24  raw asynchronous switches.
REQ-011 led  output  24  LED register.
REQ-012 dig_en  output  8  digit enables, active-low, one-hot-low.
REQ-013 dig_seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-014 Decode: addr < 0x0000_4000 -> RAM (index addr[RAM_AW+1:2]); 0xFFFF_F000 -> DIG; 0xFFFF_F060 -> LED; 0xFFFF_F070 -> SW; 0xFFFF_F020 -> TIMER (macro only); all else unmapped.
REQ-015 addr[1:0] ignored; word accesses only.
REQ-016 RAM write when we & RAM hit, committed at the clock edge; no same-cycle read bypass, new data visible the cycle after.
REQ-017 rdata: RAM word, DIG reg, {8'b0,led}, {8'b0,sw_stable}, or timer per decode; unmapped -> 0.
REQ-018 we to DIG loads wdata; we to LED loads wdata[23:0]; we to SW or unmapped is ignored.
REQ-019 sw passes through a 2-flop synchroniser before debounce.
REQ-020 Debounce per bit: synced != stable -> counter +1; counter reaches DEBOUNCE_CYC-1 -> stable <= synced, counter <= 0; synced == stable -> counter <= 0.
REQ-021 A glitch shorter than DEBOUNCE_CYC cycles never changes sw_stable.
REQ-022 Scan counter counts 0..SCAN_CYC-1; on wrap, digit index increments mod 8.
REQ-023 dig_en = ~(8'b1 << idx); dig_seg = hex glyph of DIG[4*idx+3:4*idx], dp always off (bit 7 = 1).
REQ-024 A DIG write takes effect on dig_seg the cycle after the edge, without restarting the scan.

Reset
REQ-025 While rst_n = 1 at an edge: led = 0, DIG = 0, sw_stable = 0, sync flops = 0, debounce counters = 0, scan counter = 0, idx = 0, timer = 0.
REQ-026 Outputs after reset: led = 24'h0, dig_en = 8'hFE, dig_seg = 8'hC0.
REQ-027 RAM contents are not cleared by reset.
REQ-028 Stores presented during reset are discarded, including RAM stores.

Configuration
REQ-029 Macro DMEM_BRIDGE_TIMER_EN defined: 32-bit TIMER at 0xFFFF_F020 increments every cycle; a store loads wdata, and the store wins over the increment.
REQ-030 Macro undefined: no timer logic; 0xFFFF_F020 is treated as unmapped.

Structure
REQ-031 Package dmem_bridge_pkg holds the address-map constants and the 16-entry hex-to-segment table.
REQ-032 Sub-module seg_scan holds the scan counter, digit index and glyph decode; dmem_bridge holds decode, RAM, LED, DIG, switch and timer logic.

Verification
REQ-033 Reset, then sample outputs -> led = 0, dig_en = FE, dig_seg = C0, rdata @0xFFFF_F000 = 0.
REQ-034 Store 0xDEADBEEF @0x10, then load @0x10 on the next cycle -> 0xDEADBEEF; load @0x14 unaffected; load @0x8000_0000 -> 0.
REQ-035 Store 0x12ABCDEF @0xFFFF_F060 -> led = 0xABCDEF, read = 0x00ABCDEF; store @0xFFFF_F070 -> ignored.
REQ-036 sw[0] pulsed high for 5 cycles -> read @0xFFFF_F070 stays 0; held for 25 cycles -> reads 0x1 within DEBOUNCE_CYC+3 cycles.
REQ-037 SCAN_CYC = 4, DIG = 0x76543210 -> dig_en steps FE, FD, ..., 7F every 4 cycles; dig_seg at idx 1 = F9, wraps to FE after 32 cycles.
REQ-038 With DMEM_BRIDGE_TIMER_EN: store 0xFFFF_FFFF @0xFFFF_F020, wait 2 cycles, read -> 0x1 (wrap); without the macro the read returns 0.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - address map, decode select type and hex-to-segment glyph table
package dmem_bridge_pkg;

   // Byte-address map seen from the CPU MEM stage
   localparam logic [31:0] ADDR_RAM_LIMIT = 32'h0000_4000;
   localparam logic [31:0] ADDR_DIG       = 32'hFFFF_F000;
   localparam logic [31:0] ADDR_TIMER     = 32'hFFFF_F020;
   localparam logic [31:0] ADDR_LED       = 32'hFFFF_F060;
   localparam logic [31:0] ADDR_SW        = 32'hFFFF_F070;

   localparam int SW_W  = 24;
   localparam int LED_W = 24;
   localparam int NDIG  = 8;

   typedef enum logic [2:0] {
      SEL_NONE  = 3'd0,
      SEL_RAM   = 3'd1,
      SEL_DIG   = 3'd2,
      SEL_LED   = 3'd3,
      SEL_SW    = 3'd4,
      SEL_TIMER = 3'd5
   } sel_e;

   // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost element
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   // Glyph for one nibble with the decimal point forced off
   function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
      hex_glyph = {1'b1, SEG_TABLE[nib][6:0]};
   endfunction

endpackage

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - eight-digit multiplexed seven-segment scanner
module seg_scan
   import dmem_bridge_pkg::*;
#(
   parameter int SCAN_CYC = 50000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] dig_i,
   output logic [7:0]  dig_en_o,
   output logic [7:0]  dig_seg_o
);

   localparam int SCW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

   logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [3:0]     nib;

   // Dwell counter wraps after SCAN_CYC cycles and advances the lit digit
   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (scan_cnt_q == SCW'(SCAN_CYC - 1)) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 3'd1;
      end
   end

   // Scan state register; reset is active-high despite the port name
   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
      end
   end

   // Glyph follows the live DIG value so a write shows without restarting the scan
   always_comb begin
      nib       = dig_i[{idx_q, 2'b00} +: 4];
      dig_en_o  = ~(8'b1 << idx_q);
      dig_seg_o = hex_glyph(nib);
   end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - CPU data-memory bridge: RAM, LED, DIG, debounced SW, optional TIMER (DMEM_BRIDGE_TIMER_EN)
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int RAM_AW       = 12,
   parameter int DEBOUNCE_CYC = 20,
   parameter int SCAN_CYC     = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [23:0] sw,
   output logic [23:0] led,
   output logic [7:0]  dig_en,
   output logic [7:0]  dig_seg
);

   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   logic [31:0]       word_addr;
   logic [RAM_AW-1:0] ram_idx;
   sel_e              sel;
   logic              wr_ok;

   logic [31:0]       mem [2**RAM_AW];
   logic [LED_W-1:0]  led_q, led_d;
   logic [31:0]       dig_q, dig_d;
   logic [SW_W-1:0]   sw_meta_q, sw_sync_q, sw_stable_q;
   logic [CW-1:0]     db_cnt_q [SW_W];

   // Byte lanes are ignored: every access is a whole word
   assign word_addr = addr & 32'hFFFF_FFFC;
   assign ram_idx   = word_addr[RAM_AW+1:2];
   assign wr_ok     = we && !rst_n;

   // Address decode
   always_comb begin
      sel = SEL_NONE;
      if (word_addr < ADDR_RAM_LIMIT)  sel = SEL_RAM;
      else if (word_addr == ADDR_DIG)  sel = SEL_DIG;
      else if (word_addr == ADDR_LED)  sel = SEL_LED;
      else if (word_addr == ADDR_SW)   sel = SEL_SW;
`ifdef DMEM_BRIDGE_TIMER_EN
      else if (word_addr == ADDR_TIMER) sel = SEL_TIMER;
`endif
   end

   // RAM store; contents survive reset and stores during reset are dropped
   always_ff @(posedge clk) begin
      if (wr_ok && sel == SEL_RAM) begin
         mem[ram_idx] <= wdata;
      end
   end

   // LED and DIG next state from stores
   always_comb begin
      led_d = led_q;
      dig_d = dig_q;
      if (we && sel == SEL_LED) led_d = wdata[LED_W-1:0];
      if (we && sel == SEL_DIG) dig_d = wdata;
   end

   // LED and DIG registers
   always_ff @(posedge clk) begin
      if (rst_n) begin
         led_q <= '0;
         dig_q <= '0;
      end else begin
         led_q <= led_d;
         dig_q <= dig_d;
      end
   end

   // Two-flop synchroniser for the asynchronous switches
   always_ff @(posedge clk) begin
      if (rst_n) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   // Per-bit debounce: a change is accepted only after DEBOUNCE_CYC consecutive differing cycles
   always_ff @(posedge clk) begin
      if (rst_n) begin
         sw_stable_q <= '0;
         for (int i = 0; i < SW_W; i++) db_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < SW_W; i++) begin
            if (sw_sync_q[i] == sw_stable_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
               sw_stable_q[i] <= sw_sync_q[i];
               db_cnt_q[i]    <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef DMEM_BRIDGE_TIMER_EN
   logic [31:0] timer_q, timer_d;

   // Free-running timer; a store takes priority over the increment
   always_comb begin
      timer_d = timer_q + 32'd1;
      if (we && sel == SEL_TIMER) timer_d = wdata;
   end

   // Timer register
   always_ff @(posedge clk) begin
      if (rst_n) timer_q <= '0;
      else       timer_q <= timer_d;
   end
`endif

   // Load data mux; unmapped addresses read as zero
   always_comb begin
      rdata = '0;
      case (sel)
         SEL_RAM:   rdata = mem[ram_idx];
         SEL_DIG:   rdata = dig_q;
         SEL_LED:   rdata = {8'b0, led_q};
         SEL_SW:    rdata = {8'b0, sw_stable_q};
`ifdef DMEM_BRIDGE_TIMER_EN
         SEL_TIMER: rdata = timer_q;
`endif
         default:   rdata = '0;
      endcase
   end

   assign led = led_q;

   seg_scan #(
      .SCAN_CYC (SCAN_CYC)
   ) u_seg_scan (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .dig_i     (dig_q),
      .dig_en_o  (dig_en),
      .dig_seg_o (dig_seg)
   );

endmodule
